song_sequencer: RTL

//  Initiator side of the note interface consumed by note_player. Walks a song ROM of

---
 rtl/song_sequencer_if.sv | 37 +++
 rtl/song_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/song_sequencer_if.sv
// ---------------------------------------------------------------------------
// song_sequencer_if
// Note interface between the song sequencer (master) and one note_player voice
// (slave).
//   note_stb    master -> slave  tempo tick, coincident with the frame tick
//   load        master -> slave  pitch/duration/instrument are valid
//   pitch       master -> slave  note pitch index
//   duration    master -> slave  note duration in ticks minus 1
//   instrument  master -> slave  instrument index
//   done        slave  -> master current note finished (1-cycle pulse)
// ---------------------------------------------------------------------------
interface song_sequencer_if;
    logic       note_stb;
    logic       load;
    logic [5:0] pitch;
    logic [4:0] duration;
    logic [3:0] instrument;
    logic       done;

    modport master (
        output note_stb,
        output load,
        output pitch,
        output duration,
        output instrument,
        input  done
    );

    modport slave (
        input  note_stb,
        input  load,
        input  pitch,
        input  duration,
        input  instrument,
        output done
    );
endinterface

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Walks a song ROM of packed note words ([15] END, [14:9] pitch, [8:4]
// duration, [3:0] instrument) and presents each note to a note_player through
// the note interface. Derives the tempo tick from the frame tick.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_frame_stb       1-cycle frame tick
//   i_start / i_stop  start at address 0 / abort playback
//   i_loop            restart at address 0 on the end marker
//   i_tempo           frames per tempo tick minus 1
//   note_if           note interface (master side)
//   o_busy            any state but IDLE
//   o_song_end        1-cycle pulse when the song ends without looping
//   o_song_rom_addr   ROM address (0 outside FETCH)
//   i_song_rom_data   ROM data, one cycle after the address
// ---------------------------------------------------------------------------
module song_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TEMPO_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_frame_stb,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop,
    input  logic [TEMPO_W-1:0]  i_tempo,
    song_sequencer_if.master    note_if,
    output logic                o_busy,
    output logic                o_song_end,
    output logic [ADDR_W-1:0]   o_song_rom_addr,
    input  logic [15:0]         i_song_rom_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [TEMPO_W-1:0] TICK_ZERO = {TEMPO_W{1'b0}};
    localparam logic [TEMPO_W-1:0] TICK_ONE  = {{(TEMPO_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TEMPO_W-1:0]  tick_q, tick_d;
    logic                load_q, load_d;
    logic [5:0]          pitch_q, pitch_d;
    logic [4:0]          duration_q, duration_d;
    logic [3:0]          instrument_q, instrument_d;
    logic                busy_q, busy_d;
    logic                song_end_q, song_end_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                note_stb_s;

    // Tempo tick: >= (not ==) so a tempo lowered below the running count
    // fires on the very next frame instead of waiting for a wrap.
    always_comb begin
        note_stb_s = i_frame_stb & busy_q & (tick_q >= i_tempo);
    end

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tick_d       = tick_q;
        load_d       = load_q;
        pitch_d      = pitch_q;
        duration_d   = duration_q;
        instrument_d = instrument_q;
        song_end_d   = 1'b0;

        if (busy_q && i_frame_stb) begin
            tick_d = note_stb_s ? TICK_ZERO : (tick_q + TICK_ONE);
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_FETCH;
                    addr_d  = ADDR_ZERO;
                    tick_d  = TICK_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (i_song_rom_data[15]) begin
                    // An END at address 0 means an empty song: never loop on it.
                    if (i_loop && (addr_q != ADDR_ZERO)) begin
                        addr_d  = ADDR_ZERO;
                        state_d = ST_FETCH;
                    end else begin
                        song_end_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else begin
                    pitch_d      = i_song_rom_data[14:9];
                    duration_d   = i_song_rom_data[8:4];
                    instrument_d = i_song_rom_data[3:0];
                    load_d       = 1'b1;
                    addr_d       = addr_q + ADDR_ONE;
                    state_d      = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (note_if.done) begin
                    load_d  = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stop overrides everything, including a same-cycle start.
        if (i_stop) begin
            state_d    = ST_IDLE;
            load_d     = 1'b0;
            tick_d     = TICK_ZERO;
            song_end_d = 1'b0;
        end else begin
            state_d = state_d;
        end

        busy_d     = (state_d != ST_IDLE);
        rom_addr_d = (state_d == ST_FETCH) ? addr_d : ADDR_ZERO;
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= ADDR_ZERO;
            tick_q       <= TICK_ZERO;
            load_q       <= 1'b0;
            pitch_q      <= 6'd0;
            duration_q   <= 5'd0;
            instrument_q <= 4'd0;
            busy_q       <= 1'b0;
            song_end_q   <= 1'b0;
            rom_addr_q   <= ADDR_ZERO;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tick_q       <= tick_d;
            load_q       <= load_d;
            pitch_q      <= pitch_d;
            duration_q   <= duration_d;
            instrument_q <= instrument_d;
            busy_q       <= busy_d;
            song_end_q   <= song_end_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    assign note_if.note_stb   = note_stb_s;
    assign note_if.load       = load_q;
    assign note_if.pitch      = pitch_q;
    assign note_if.duration   = duration_q;
    assign note_if.instrument = instrument_q;
    assign o_busy             = busy_q;
    assign o_song_end         = song_end_q;
    assign o_song_rom_addr    = rom_addr_q;

endmodule
